// File: rtl/clk_rate_ctrl_if.sv
// clk_rate_ctrl_if: speed requests and rate status of the clock-rate controller
interface clk_rate_ctrl_if;
  logic up, dn, pause, busy, tick, sys_clk;
  logic [4:0] sel;
  modport master (output up, dn, pause, input sel, busy, tick, sys_clk);
  modport slave (input up, dn, pause, output sel, busy, tick, sys_clk);
endinterface

// File: rtl/clk_rate_ctrl.sv
// clk_rate_ctrl: tap-select divider whose rate changes only on a period boundary
module clk_rate_ctrl #(
  parameter int CNT_W = 32,
  parameter int SEL_MIN = 0,
  parameter int SEL_MAX = 26,
  parameter int SEL_INIT = 24
) (
  input logic clk,
  input logic rst,
  clk_rate_ctrl_if.slave bus
);
  localparam logic [4:0] S_MIN = 5'(SEL_MIN);
  localparam logic [4:0] S_MAX = 5'(SEL_MAX);
  localparam logic [4:0] S_INIT = 5'(SEL_INIT);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_sh, cnt_n_sh;
  logic [4:0] sel, sel_n, sel_eff, pend, base, tgt;
  logic tick, tap, tap_q, tap_q_n, up_q, dn_q, up_e, dn_e, req, edge_c, swap, busy;
  // request decode, saturating target and the rate swap; a freshly selected tap
  // seeds tap_q from the next counter value so the swap never fakes an edge
  always_comb begin
    cnt_n = bus.pause ? cnt : cnt + CNT_W'(1);
    cnt_sh = cnt >> sel;
    tap = cnt_sh[0];
    edge_c = tap & ~tap_q;
    up_e = bus.up & ~up_q;
    dn_e = bus.dn & ~dn_q;
    req = up_e ^ dn_e;
    swap = busy & (edge_c | bus.pause);
    sel_eff = swap ? pend : sel;
    base = busy ? pend : sel;
    tgt = up_e ? (base >= S_MAX ? S_MAX : base + 5'd1) : (base <= S_MIN ? S_MIN : base - 5'd1);
    sel_n = (req & bus.pause) ? tgt : sel_eff;
    cnt_n_sh = cnt_n >> sel_n;
    tap_q_n = (sel_n != sel) ? cnt_n_sh[0] : tap;
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // FSM next state: wait for a boundary only when the target differs and we are running
  always_comb begin
    state_n = req ? ((!bus.pause && tgt != sel_eff) ? WAIT : IDLE) : (swap ? IDLE : state);
  end
  // FSM and status outputs
  always_comb begin
    busy = state == WAIT;
    bus.busy = busy;
    bus.sel = sel;
    bus.tick = tick;
    bus.sys_clk = tap;
  end
  // counter, applied tap, pending target, tick and input edge history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sel <= S_INIT;
      pend <= S_INIT;
      tick <= 1'b0;
      tap_q <= 1'b0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sel <= sel_n;
      pend <= req ? tgt : pend;
      tick <= edge_c & ~bus.pause;
      tap_q <= tap_q_n;
      up_q <= bus.up;
      dn_q <= bus.dn;
    end
endmodule

// File: tb/tb_clk_rate_ctrl.sv
// tb_clk_rate_ctrl: scoreboard bench for the clock-rate controller
module tb_clk_rate_ctrl;
  typedef struct { logic u, d, p; logic [4:0] es; logic eb, et; } vec_t;
  typedef struct { logic [4:0] sel; logic busy, tick, sys; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int cnt_m = 0;
  exp_t sb[$];
  exp_t m;
  vec_t tbl[$];
  clk_rate_ctrl_if bus();
  clk_rate_ctrl #(.CNT_W(16), .SEL_MIN(0), .SEL_MAX(5), .SEL_INIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic logic ftick(input int c, input int s);
    return ((c - (1 << s) - 1) & ((2 << s) - 1)) == 0;
  endfunction
  task automatic add(input logic u, d, p, input logic [4:0] es, input logic eb, et, input int n);
    repeat (n) tbl.push_back('{u, d, p, es, eb, et});
  endtask
  task automatic cyc(input logic u, d, p, input logic [4:0] es, input logic eb, et);
    int c;
    exp_t e;
    bus.up = u;
    bus.dn = d;
    bus.pause = p;
    c = p ? cnt_m : cnt_m + 1;
    e.sel = es;
    e.busy = eb;
    e.tick = et;
    e.sys = 1'((c >> es) & 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cnt_m = c;
  endtask
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk("sel", int'(bus.sel), int'(m.sel));
      chk("busy", int'(bus.busy), int'(m.busy));
      chk("tick", int'(bus.tick), int'(m.tick));
      chk("sys_clk", int'(bus.sys_clk), int'(m.sys));
    end
  end
  initial begin
    bus.up = 1'b0;
    bus.dn = 1'b0;
    bus.pause = 1'b0;
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1);
    for (int s = 1; s <= 4; s++) begin
      add(1, 0, 1, 5'(s), 0, 0, 1);
      add(0, 0, 1, 5'(s), 0, 0, 1);
    end
    add(1, 0, 1, 5, 0, 0, 1);
    add(0, 0, 1, 5, 0, 0, 1);
    add(1, 0, 1, 5, 0, 0, 1);
    add(0, 0, 1, 5, 0, 0, 8);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 0, 0, 5, 0, 1, 1);
    add(1, 0, 0, 5, 0, 0, 4);
    add(0, 0, 0, 5, 0, 0, 1);
    add(0, 1, 0, 5, 1, 0, 1);
    add(0, 0, 0, 5, 1, 0, 1);
    add(0, 0, 1, 4, 0, 0, 2);
    add(0, 0, 0, 4, 0, 0, 1);
    #12;
    chk("rst_sel", int'(bus.sel), 2);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_sys_clk", int'(bus.sys_clk), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) cyc(0, 0, 0, 2, 0, ftick(cnt_m + 1, 2));
    for (int i = 41; i <= 64; i++)
      cyc(i == 41, 0, 0, 5'(i >= 45 ? 3 : 2), i < 45, ftick(i, i <= 45 ? 2 : 3));
    for (int i = 65; i <= 90; i++)
      cyc(0, i == 65 || i == 67 || i == 69, 0, 5'(i >= 73 ? 0 : 3), i < 73,
          i <= 73 ? ftick(i, 3) : (i != 74) && ftick(i, 0));
    foreach (tbl[k]) cyc(tbl[k].u, tbl[k].d, tbl[k].p, tbl[k].es, tbl[k].eb, tbl[k].et);
    repeat (20) cyc(0, 0, 0, 4, 0, ftick(cnt_m + 1, 4));
    cyc(0, 1, 0, 4, 1, ftick(cnt_m + 1, 4));
    repeat (2) cyc(0, 0, 0, 4, 1, ftick(cnt_m + 1, 4));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", int'(bus.sel), 2);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_tick", int'(bus.tick), 0);
    chk("mid_rst_sys_clk", int'(bus.sys_clk), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    repeat (16) cyc(0, 0, 0, 2, 0, ftick(cnt_m + 1, 2));
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
